// File: rtl/decoder_pipe.sv
// Binary-to-vector decoder with a valid/ready pipeline stage.
// A main register plus one skid register keeps in_ready purely registered.
module decoder_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OUT_W-1:0] r_main_data;
  logic             r_main_err;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_err;
  logic [7:0]       r_err_cnt;

  logic             w_acc;
  logic             w_dlv;
  logic             w_oob;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_pop_skid;
  logic [OUT_W-1:0] w_hot;
  logic [OUT_W-1:0] w_thermo;
  logic [OUT_W-1:0] w_dec_data;
  logic             w_dec_err;

  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;
  assign err_cnt   = r_err_cnt;

  assign w_acc = in_valid && in_ready;
  assign w_dlv = out_valid && out_ready;

  // OUT_W <= 2**IN_W, so one extra bit holds it exactly.
  assign w_oob = ({1'b0, in_code} >= (IN_W + 1)'(OUT_W));

  always_comb begin
    w_hot    = '0;
    w_thermo = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_hot[i]    = (in_code == IN_W'(i));
      w_thermo[i] = (IN_W'(i) <= in_code);
    end
  end

  always_comb begin
    w_dec_data = '0;
    w_dec_err  = 1'b0;
    if (w_oob) begin
      w_dec_err = 1'b1;
    end else begin
      case (in_mode)
        2'b00:   w_dec_data = w_hot;
        2'b01:   w_dec_data = w_thermo;
        2'b10:   w_dec_data = ~w_hot;
        default: w_dec_err  = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY: if (w_acc) w_next = ONE;
      ONE: begin
        if (w_acc && !w_dlv)      w_next = TWO;
        else if (!w_acc && w_dlv) w_next = EMPTY;
      end
      TWO:     if (w_dlv) w_next = ONE;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  assign w_load_main = w_acc && ((r_state == EMPTY) || w_dlv);
  assign w_load_skid = w_acc && (r_state == ONE) && !w_dlv;
  assign w_pop_skid  = w_dlv && (r_state == TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_dec_data;
        r_main_err  <= w_dec_err;
      end else if (w_pop_skid) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_dec_data;
        r_skid_err  <= w_dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_dlv && r_main_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
